// File: rtl/rst_vector_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rst_vector_sequencer_pkg
//  Description : Shared FSM encoding, RST opcode decode constants and vector
//                defaults for the restart-class sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rst_vector_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUSH_HI = 2'd1,
        ST_PUSH_LO = 2'd2,
        ST_LOAD    = 2'd3
    } state_t;

    // RST p opcodes are 11ppp111: the ppp field is the only don't-care.
    localparam logic [7:0]  c_rst_mask      = 8'b1100_0111;
    localparam logic [7:0]  c_rst_match     = 8'b1100_0111;

    localparam int          c_vec_bits_def  = 3;
    localparam int          c_vec_shift_def = 3;
    localparam int          c_irq_index_def = 7;
    localparam logic [15:0] c_vec_base_def  = 16'h0000;

    function automatic logic is_rst_opcode(input logic [7:0] op);
        return (op & c_rst_mask) == c_rst_match;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_vector_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rst_vector_sequencer_if
//  Description : Decoder/stack-memory/PC-control bundle of the RST sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rst_vector_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic              start;
    logic [7:0]        opcode;
    logic              irq_req;
    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] sp_in;
    logic              mem_ready;
    logic              busy;
    logic              irq_ack;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              sp_dec;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_value;
    logic              xpt_reset;

    modport master (
        output start, opcode, irq_req, pc_in, sp_in, mem_ready,
        input  busy, irq_ack, mem_wr, mem_addr, mem_wdata, sp_dec,
               pc_load, pc_value, xpt_reset
    );

    modport slave (
        input  start, opcode, irq_req, pc_in, sp_in, mem_ready,
        output busy, irq_ack, mem_wr, mem_addr, mem_wdata, sp_dec,
               pc_load, pc_value, xpt_reset
    );

endinterface
`default_nettype wire

// File: rtl/rst_vector_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rst_vector_gen
//  Description : Combinational vector index to restart address mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_vector_gen
    import rst_vector_sequencer_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                VEC_BITS  = c_vec_bits_def,
    parameter int                VEC_SHIFT = c_vec_shift_def,
    parameter logic [ADDR_W-1:0] VEC_BASE  = ADDR_W'(c_vec_base_def)
) (
    input  wire logic [VEC_BITS-1:0] i_idx,
    output logic      [ADDR_W-1:0]   o_vector
);

    logic [ADDR_W-1:0] w_idx_ext;

    assign w_idx_ext = ADDR_W'(i_idx);
    // Sum is deliberately truncated to ADDR_W so a high base wraps.
    assign o_vector  = VEC_BASE + (w_idx_ext << VEC_SHIFT);

endmodule
`default_nettype wire

// File: rtl/rst_vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rst_vector_sequencer
//  Description : Pushes the return PC (high byte first) with a wait-state
//                handshake, then loads the RST/IRQ vector and restarts fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_vector_sequencer
    import rst_vector_sequencer_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 16,
    parameter int                VEC_BITS  = c_vec_bits_def,
    parameter int                VEC_SHIFT = c_vec_shift_def,
    parameter logic [ADDR_W-1:0] VEC_BASE  = ADDR_W'(c_vec_base_def),
    parameter int                IRQ_INDEX = c_irq_index_def
) (
    input  wire logic            clk,
    input  wire logic            notReset,
    rst_vector_sequencer_if.slave bus
);

    generate
        if (ADDR_W != 2 * DATA_W) begin : g_width_check
            $error("rst_vector_sequencer: ADDR_W must equal 2*DATA_W");
        end
    endgenerate

    state_t              r_state;
    logic [DATA_W-1:0]   r_pc_lo;
    logic [ADDR_W-1:0]   r_sp;
    logic [VEC_BITS-1:0] r_idx;
    logic                r_busy;
    logic                r_irq_ack;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_pc_load;
    logic [ADDR_W-1:0]   r_pc_value;
    logic                r_xpt_reset;

    logic                w_rst_hit;
    logic                w_accept;
    logic [VEC_BITS-1:0] w_accept_idx;
    logic [ADDR_W-1:0]   w_vector;
    logic                w_wr_done;

    assign w_rst_hit    = bus.start && is_rst_opcode(bus.opcode);
    assign w_accept     = bus.irq_req || w_rst_hit;
    assign w_accept_idx = bus.irq_req ? VEC_BITS'(IRQ_INDEX)
                                      : bus.opcode[3 +: VEC_BITS];
    // A write completes only while a request is outstanding; stray ready is ignored.
    assign w_wr_done    = r_mem_wr && bus.mem_ready;

    rst_vector_gen #(
        .ADDR_W    (ADDR_W),
        .VEC_BITS  (VEC_BITS),
        .VEC_SHIFT (VEC_SHIFT),
        .VEC_BASE  (VEC_BASE)
    ) u_vector_gen (
        .i_idx    (r_idx),
        .o_vector (w_vector)
    );

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            r_state     <= ST_IDLE;
            r_pc_lo     <= '0;
            r_sp        <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_irq_ack   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pc_load   <= 1'b0;
            r_pc_value  <= '0;
            r_xpt_reset <= 1'b0;
        end else begin
            r_irq_ack   <= 1'b0;
            r_pc_load   <= 1'b0;
            r_xpt_reset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // The high byte goes straight into the write register,
                        // so only the low byte of the return PC is kept.
                        r_irq_ack   <= bus.irq_req;
                        r_idx       <= w_accept_idx;
                        r_pc_lo     <= bus.pc_in[DATA_W-1:0];
                        r_sp        <= bus.sp_in;
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= bus.sp_in - ADDR_W'(1);
                        r_mem_wdata <= bus.pc_in[ADDR_W-1:DATA_W];
                        r_busy      <= 1'b1;
                        r_state     <= ST_PUSH_HI;
                    end
                end
                ST_PUSH_HI: begin
                    if (bus.mem_ready) begin
                        r_sp        <= r_sp - ADDR_W'(1);
                        r_mem_addr  <= r_sp - ADDR_W'(2);
                        r_mem_wdata <= r_pc_lo;
                        r_state     <= ST_PUSH_LO;
                    end
                end
                ST_PUSH_LO: begin
                    if (bus.mem_ready) begin
                        r_sp        <= r_sp - ADDR_W'(1);
                        r_mem_wr    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_pc_load   <= 1'b1;
                        r_xpt_reset <= 1'b1;
                        r_pc_value  <= w_vector;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_pc_value <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_mem_wr <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.irq_ack   = r_irq_ack;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.sp_dec    = w_wr_done;
    assign bus.pc_load   = r_pc_load;
    assign bus.pc_value  = r_pc_value;
    assign bus.xpt_reset = r_xpt_reset;

endmodule
`default_nettype wire
